noc_traffic_node: RTL

Parametrised NoC traffic endpoint: a generator that injects a configurable number of header/body/tail packets toward a fixed destination, plus a checker that validates every incoming packet's framing and payload. It connects to one router local port: one sender channel and one receiver channel, virtual channel 0. It is the standard stimulus/monitor node for mesh-level simulation of the `Noc_parameters.v` fabric.

---
 rtl/noc_traffic_node.sv | 284 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/noc_traffic_node.sv
// NoC traffic endpoint: packet generator plus framing/payload checker on one router local port.
// Optional build macro NOC_TRAFFIC_PAYLOAD_CHECK_EN adds body payload comparison in the receiver.
`ifndef Noc_Data_Width
`define Noc_Data_Width 64
`endif
`ifndef Noc_ID_X_Width
`define Noc_ID_X_Width 4
`endif
`ifndef Noc_ID_Y_Width
`define Noc_ID_Y_Width 4
`endif
`ifndef Axi_LEN_Bit
`define Axi_LEN_Bit 8
`endif
`ifndef Noc_Head_H
`define Noc_Head_H 8'hA5
`endif
`ifndef Noc_Head_E
`define Noc_Head_E 8'h5A
`endif
`ifndef Noc_Tail_H
`define Noc_Tail_H 8'hC3
`endif
`ifndef Noc_Tail_E
`define Noc_Tail_E 8'h3C
`endif

module noc_traffic_node #(
  parameter int X_ID       = 0,
  parameter int Y_ID       = 0,
  parameter int DEST_X_ID  = 0,
  parameter int DEST_Y_ID  = 0,
  parameter int BODY_FLITS = 1,
  parameter int PKT_COUNT  = 1,
  parameter int GAP_CYCLES = 0
) (
  input  logic                       noc_clk,
  input  logic                       noc_rst_n,
  input  logic                       send_start,
  input  logic                       send_stop,
  output logic                       send_busy,
  output logic                       send_done,
  output logic                       sender_valid,
  input  logic                       sender_ready,
  output logic [`Noc_Data_Width-1:0] sender_flit,
  output logic                       sender_is_header,
  output logic                       sender_is_tail,
  input  logic                       receive_valid,
  output logic                       receive_ready,
  input  logic [`Noc_Data_Width-1:0] receive_flit,
  input  logic                       receive_is_header,
  input  logic                       receive_is_tail,
  output logic [15:0]                rx_pkt_cnt,
  output logic [15:0]                rx_err_cnt,
  output logic [`Noc_ID_X_Width-1:0] rx_last_src_x,
  output logic [`Noc_ID_Y_Width-1:0] rx_last_src_y
);
  localparam int DW = `Noc_Data_Width;
  localparam int XW = `Noc_ID_X_Width;
  localparam int YW = `Noc_ID_Y_Width;
  localparam int LW = `Axi_LEN_Bit;
  localparam int MW = 8;
  // Header/tail layout, MSB first: marker, src x/y, dest x/y, type(2), order(2), len, end marker, pad.
  localparam int H_LSB   = DW - MW;
  localparam int SX_LSB  = H_LSB - XW;
  localparam int SY_LSB  = SX_LSB - YW;
  localparam int DX_LSB  = SY_LSB - XW;
  localparam int DY_LSB  = DX_LSB - YW;
  localparam int LEN_LSB = DY_LSB - 4 - LW;
  localparam int E_LSB   = LEN_LSB - MW;
  localparam logic [LW-1:0] HDR_LEN   = LW'(BODY_FLITS - 1);
  localparam logic [LW:0]   LAST_BEAT = (LW+1)'(BODY_FLITS - 1);
  localparam logic [15:0]   LAST_PKT  = 16'(PKT_COUNT - 1);
  localparam logic [7:0]    GAP_LAST  = 8'(GAP_CYCLES - 1);
  localparam bit            CONT      = (PKT_COUNT == 0);

  function automatic logic [DW-1:0] frame_flit(input logic tail);
    logic [DW-1:0] f;
    f = '0;
    f[H_LSB +: MW]   = tail ? `Noc_Tail_H : `Noc_Head_H;
    f[SX_LSB +: XW]  = XW'(X_ID);
    f[SY_LSB +: YW]  = YW'(Y_ID);
    f[DX_LSB +: XW]  = XW'(DEST_X_ID);
    f[DY_LSB +: YW]  = YW'(DEST_Y_ID);
    f[LEN_LSB +: LW] = HDR_LEN;
    f[E_LSB +: MW]   = tail ? `Noc_Tail_E : `Noc_Head_E;
    return f;
  endfunction

  function automatic logic [DW-1:0] body_flit(input logic [7:0] p, input logic [7:0] k);
    return {{(DW-16){1'b0}}, p, k};
  endfunction

  function automatic logic marks_ok(input logic [DW-1:0] f, input logic tail);
    if (tail) return (f[H_LSB +: MW] == `Noc_Tail_H) && (f[E_LSB +: MW] == `Noc_Tail_E);
    return (f[H_LSB +: MW] == `Noc_Head_H) && (f[E_LSB +: MW] == `Noc_Head_E);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  typedef enum logic [2:0] {S_IDLE, S_HEAD, S_BODY, S_TAIL, S_GAP} s_state_t;
  typedef enum logic [1:0] {R_HEAD, R_BODY, R_TAIL} r_state_t;

  s_state_t      s_state;
  logic [15:0]   pkt;
  logic [LW:0]   beat;
  logic [LW:0]   beat_nxt;
  logic [7:0]    gap_cnt;
  logic          stop_lat;
  logic          tx_fire;

  assign tx_fire  = sender_valid && sender_ready;
  assign beat_nxt = beat + (LW+1)'(1);

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      s_state          <= S_IDLE;
      pkt              <= '0;
      beat             <= '0;
      gap_cnt          <= '0;
      stop_lat         <= 1'b0;
      send_busy        <= 1'b0;
      send_done        <= 1'b0;
      sender_valid     <= 1'b0;
      sender_flit      <= '0;
      sender_is_header <= 1'b0;
      sender_is_tail   <= 1'b0;
    end else begin
      send_done <= 1'b0;
      if (CONT && send_stop && s_state != S_IDLE) stop_lat <= 1'b1;
      case (s_state)
        S_IDLE: if (send_start) begin
          s_state          <= S_HEAD;
          send_busy        <= 1'b1;
          pkt              <= '0;
          stop_lat         <= 1'b0;
          sender_valid     <= 1'b1;
          sender_flit      <= frame_flit(1'b0);
          sender_is_header <= 1'b1;
        end
        S_HEAD: if (tx_fire) begin
          s_state          <= S_BODY;
          beat             <= '0;
          sender_flit      <= body_flit(pkt[7:0], 8'd0);
          sender_is_header <= 1'b0;
        end
        S_BODY: if (tx_fire) begin
          if (beat == LAST_BEAT) begin
            s_state        <= S_TAIL;
            sender_flit    <= frame_flit(1'b1);
            sender_is_tail <= 1'b1;
          end else begin
            beat        <= beat_nxt;
            sender_flit <= body_flit(pkt[7:0], beat_nxt[7:0]);
          end
        end
        S_TAIL: if (tx_fire) begin
          sender_is_tail <= 1'b0;
          // A stop arriving on the tail beat itself still ends the burst here.
          if ((CONT && (stop_lat || send_stop)) || (!CONT && pkt == LAST_PKT)) begin
            s_state      <= S_IDLE;
            send_busy    <= 1'b0;
            send_done    <= 1'b1;
            sender_valid <= 1'b0;
            sender_flit  <= '0;
          end else begin
            pkt <= pkt + 16'd1;
            if (GAP_CYCLES == 0) begin
              s_state          <= S_HEAD;
              sender_flit      <= frame_flit(1'b0);
              sender_is_header <= 1'b1;
            end else begin
              s_state      <= S_GAP;
              gap_cnt      <= GAP_LAST;
              sender_valid <= 1'b0;
              sender_flit  <= '0;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == 8'd0) begin
            s_state          <= S_HEAD;
            sender_valid     <= 1'b1;
            sender_flit      <= frame_flit(1'b0);
            sender_is_header <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        default: s_state <= S_IDLE;
      endcase
    end
  end

  r_state_t      r_state;
  logic [XW-1:0] cur_x;
  logic [YW-1:0] cur_y;
  logic [LW-1:0] rx_len;
  logic [LW:0]   rx_beat;
  logic          pay_bad;
  logic          pay_mis;
  logic          rx_fire;
  logic          hdr_ok;
  logic          tail_ok;

  assign rx_fire = receive_valid && receive_ready;
  assign hdr_ok  = receive_is_header && marks_ok(receive_flit, 1'b0);
  assign tail_ok = receive_is_tail && !receive_is_header && marks_ok(receive_flit, 1'b1);

`ifdef NOC_TRAFFIC_PAYLOAD_CHECK_EN
  logic [7:0] rx_p;
  always_comb begin
    pay_mis = 1'b0;
    if (rx_beat == '0) pay_mis = (receive_flit != body_flit(receive_flit[15:8], 8'd0));
    else pay_mis = (receive_flit != body_flit(rx_p, rx_beat[7:0]));
  end
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) rx_p <= '0;
    else if (rx_fire && r_state == R_BODY && rx_beat == '0) rx_p <= receive_flit[15:8];
  end
`else
  assign pay_mis = 1'b0;
`endif

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      r_state       <= R_HEAD;
      receive_ready <= 1'b0;
      cur_x         <= '0;
      cur_y         <= '0;
      rx_len        <= '0;
      rx_beat       <= '0;
      pay_bad       <= 1'b0;
      rx_pkt_cnt    <= '0;
      rx_err_cnt    <= '0;
      rx_last_src_x <= '0;
      rx_last_src_y <= '0;
    end else begin
      receive_ready <= 1'b1;
      if (rx_fire) begin
        case (r_state)
          R_HEAD: if (hdr_ok) r_state <= R_BODY;
                  else rx_err_cnt <= sat_inc(rx_err_cnt);
          R_BODY: begin
            if (receive_is_header) begin
              rx_err_cnt <= sat_inc(rx_err_cnt);
              r_state    <= hdr_ok ? R_BODY : R_HEAD;
            end else if (receive_is_tail) begin
              rx_err_cnt <= sat_inc(rx_err_cnt);
              r_state    <= R_HEAD;
            end else begin
              if (pay_mis) begin
                rx_err_cnt <= sat_inc(rx_err_cnt);
                pay_bad    <= 1'b1;
              end
              if (rx_beat == {1'b0, rx_len}) r_state <= R_TAIL;
              else rx_beat <= rx_beat + (LW+1)'(1);
            end
          end
          R_TAIL: begin
            r_state <= R_HEAD;
            if (!tail_ok) rx_err_cnt <= sat_inc(rx_err_cnt);
            else if (!pay_bad) begin
              rx_pkt_cnt    <= sat_inc(rx_pkt_cnt);
              rx_last_src_x <= cur_x;
              rx_last_src_y <= cur_y;
            end
          end
          default: r_state <= R_HEAD;
        endcase
        // Any well-formed header seen outside R_TAIL (re)starts packet context.
        if (hdr_ok && r_state != R_TAIL) begin
          cur_x   <= receive_flit[SX_LSB +: XW];
          cur_y   <= receive_flit[SY_LSB +: YW];
          rx_len  <= receive_flit[LEN_LSB +: LW];
          rx_beat <= '0;
          pay_bad <= 1'b0;
        end
      end
    end
  end
endmodule
